// File: rtl/pattern_generator.sv
// Reaction-game target generator: LFSR-sourced 8-bit patterns sequenced as
// blank-gap / show rounds, paced by the 10 Hz tick strobe.
module pattern_generator #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int unsigned GAP_TICKS  = 3,
    parameter int unsigned HOLD_TICKS = 20,
    parameter int unsigned NUM_ROUNDS = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start,
    input  logic [7:0] user_input,
    output logic [7:0] pattern,
    output logic       pattern_valid,
    output logic [7:0] round_count,
    output logic       busy,
    output logic       done
);

    localparam logic [15:0] LFSR_INIT  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  GAP_LAST   = 8'(GAP_TICKS - 1);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_TICKS - 1);
    localparam logic [7:0]  ROUND_LAST = 8'(NUM_ROUNDS);

    typedef enum logic [1:0] {StIdle, StGap, StShow, StDone} state_t;

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [7:0]  r_prev;
    logic [7:0]  r_cnt;
    logic [7:0]  r_pattern;
    logic        r_valid;
    logic [7:0]  r_round;
    logic        r_busy;
    logic        r_done;

    logic        w_fb;
    logic [7:0]  w_cand_a;
    logic [7:0]  w_cand;
    logic [7:0]  w_round_next;
    logic        w_gap_last;
    logic        w_hold_last;
    logic        w_match;

    assign w_fb         = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_round_next = r_round + 8'd1;
    assign w_gap_last   = tick && (r_cnt == GAP_LAST);
    assign w_hold_last  = tick && (r_cnt == HOLD_LAST);
    assign w_match      = (user_input == r_pattern);

    // Candidate is forced nonzero, then forced to differ from the previous round.
    always_comb begin
        w_cand_a = (r_lfsr[7:0] == 8'h00) ? 8'h01 : r_lfsr[7:0];
        w_cand   = w_cand_a;
        if (w_cand_a == r_prev) begin
            w_cand = (w_cand_a == 8'hFF) ? 8'h7F : {w_cand_a[6:0], w_cand_a[7]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_lfsr    <= LFSR_INIT;
            r_prev    <= 8'h00;
            r_cnt     <= 8'h00;
            r_pattern <= 8'h00;
            r_valid   <= 1'b0;
            r_round   <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (tick) begin
                r_lfsr <= {r_lfsr[14:0], w_fb};
            end
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state   <= StGap;
                        r_round   <= 8'h00;
                        r_cnt     <= 8'h00;
                        r_pattern <= 8'h00;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                StGap: begin
                    if (w_gap_last) begin
                        r_state   <= StShow;
                        r_pattern <= w_cand;
                        r_prev    <= w_cand;
                        r_valid   <= 1'b1;
                        r_cnt     <= 8'h00;
                    end else if (tick) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                StShow: begin
                    // A match and a hold-expiry tick together still end one round.
                    if (w_match || w_hold_last) begin
                        r_round   <= w_round_next;
                        r_pattern <= 8'h00;
                        r_valid   <= 1'b0;
                        r_cnt     <= 8'h00;
                        if (w_round_next == ROUND_LAST) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StGap;
                        end
                    end else if (tick) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign pattern       = r_pattern;
    assign pattern_valid = r_valid;
    assign round_count   = r_round;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_pattern_generator.sv
// Self-checking bench for pattern_generator: hand-written game sequences on one
// instance, a table of pattern-rule vectors on a second instance.
module tb_pattern_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       a_tick, a_start;
    logic [7:0] a_ui;
    logic [7:0] a_pattern, a_round;
    logic       a_valid, a_busy, a_done;
    logic       b_tick, b_start;
    logic [7:0] b_ui;
    logic [7:0] b_pattern, b_round;
    logic       b_valid, b_busy, b_done;

    pattern_generator #(
        .SEED(16'hACE1), .GAP_TICKS(3), .HOLD_TICKS(20), .NUM_ROUNDS(2)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .tick(a_tick), .start(a_start),
        .user_input(a_ui), .pattern(a_pattern), .pattern_valid(a_valid),
        .round_count(a_round), .busy(a_busy), .done(a_done)
    );

    pattern_generator #(
        .SEED(16'h003C), .GAP_TICKS(1), .HOLD_TICKS(20), .NUM_ROUNDS(1)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .tick(b_tick), .start(b_start),
        .user_input(b_ui), .pattern(b_pattern), .pattern_valid(b_valid),
        .round_count(b_round), .busy(b_busy), .done(b_done)
    );

    typedef struct {
        logic [7:0] target;
        logic [7:0] expect_pat;
    } vec_t;

    int          n_run = 0;
    int          n_fail = 0;
    logic [15:0] m_a, m_b;
    logic [7:0]  prev_a, exp_a;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [7:0] pick(input logic [7:0] raw, input logic [7:0] prev);
        logic [7:0] c;
        c = (raw == 8'h00) ? 8'h01 : raw;
        if (c == prev) c = (c == 8'hFF) ? 8'h7F : {c[6:0], c[7]};
        return c;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_a_t();
        a_tick = 1'b1;
        cyc(1);
        a_tick = 1'b0;
        m_a = lfsr_step(m_a);
    endtask

    task automatic tick_b_t();
        b_tick = 1'b1;
        cyc(1);
        b_tick = 1'b0;
        m_b = lfsr_step(m_b);
    endtask

    task automatic start_a_t();
        a_start = 1'b1;
        cyc(1);
        a_start = 1'b0;
    endtask

    // Three gap ticks with an idle cycle between; the last one loads the pattern.
    task automatic gap_a();
        tick_a_t();
        cyc(1);
        tick_a_t();
        check("gap_blank", {8'h00, a_pattern}, 16'h0000);
        exp_a  = pick(m_a[7:0], prev_a);
        prev_a = exp_a;
        tick_a_t();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   k;
        vecs[0] = '{8'h3C, 8'h3C};
        vecs[1] = '{8'h3C, 8'h78};
        vecs[2] = '{8'hFF, 8'hFF};
        vecs[3] = '{8'hFF, 8'h7F};
        vecs[4] = '{8'h00, 8'h01};
        vecs[5] = '{8'h00, 8'h02};

        reset_n = 1'b0;
        a_tick = 1'b0; a_start = 1'b0; a_ui = 8'h00;
        b_tick = 1'b0; b_start = 1'b0; b_ui = 8'h00;
        m_a = 16'hACE1; m_b = 16'h003C; prev_a = 8'h00; exp_a = 8'h00;
        #12;
        reset_n = 1'b1;
        cyc(1);
        check("rst_pattern", {8'h00, a_pattern}, 16'h0000);
        check("rst_valid", {15'h0, a_valid}, 16'h0000);
        check("rst_round", {8'h00, a_round}, 16'h0000);
        check("rst_busy", {15'h0, a_busy}, 16'h0000);
        check("rst_done", {15'h0, a_done}, 16'h0000);

        start_a_t();
        check("start_busy", {15'h0, a_busy}, 16'h0001);
        check("start_valid", {15'h0, a_valid}, 16'h0000);

        gap_a();
        check("first_pattern", {8'h00, a_pattern}, 16'h0087);
        check("first_valid", {15'h0, a_valid}, 16'h0001);

        repeat (19) begin
            tick_a_t();
            cyc(1);
        end
        check("hold_19", {8'h00, a_pattern}, 16'h0087);
        tick_a_t();
        check("hold_end_pattern", {8'h00, a_pattern}, 16'h0000);
        check("hold_end_valid", {15'h0, a_valid}, 16'h0000);
        check("hold_end_round", {8'h00, a_round}, 16'h0001);
        check("hold_end_busy", {15'h0, a_busy}, 16'h0001);

        gap_a();
        check("r2_pattern", {8'h00, a_pattern}, {8'h00, exp_a});
        cyc(2);
        a_ui = exp_a;
        cyc(1);
        a_ui = 8'h00;
        check("match_pattern", {8'h00, a_pattern}, 16'h0000);
        check("match_round", {8'h00, a_round}, 16'h0002);
        check("done_flag", {15'h0, a_done}, 16'h0001);
        check("done_busy", {15'h0, a_busy}, 16'h0000);
        tick_a_t();
        tick_a_t();
        check("done_held", {8'h00, a_round}, 16'h0002);

        start_a_t();
        check("restart_round", {8'h00, a_round}, 16'h0000);
        check("restart_busy", {15'h0, a_busy}, 16'h0001);
        check("restart_done", {15'h0, a_done}, 16'h0000);

        gap_a();
        check("g3_pattern", {8'h00, a_pattern}, {8'h00, exp_a});
        a_ui = exp_a;
        a_tick = 1'b1;
        cyc(1);
        a_tick = 1'b0;
        a_ui = 8'h00;
        m_a = lfsr_step(m_a);
        check("both_round", {8'h00, a_round}, 16'h0001);
        check("both_busy", {15'h0, a_busy}, 16'h0001);

        gap_a();
        check("g3r2_pattern", {8'h00, a_pattern}, {8'h00, exp_a});
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_pattern", {8'h00, a_pattern}, 16'h0000);
        check("arst_valid", {15'h0, a_valid}, 16'h0000);
        check("arst_round", {8'h00, a_round}, 16'h0000);
        check("arst_busy", {15'h0, a_busy}, 16'h0000);
        #2;
        reset_n = 1'b1;
        m_a = 16'hACE1; m_b = 16'h003C; prev_a = 8'h00;
        cyc(1);
        start_a_t();
        gap_a();
        check("replay_pattern", {8'h00, a_pattern}, 16'h0087);

        for (int i = 0; i < 6; i++) begin
            k = 0;
            while (m_b[7:0] != vecs[i].target && k < 8000) begin
                tick_b_t();
                k++;
            end
            if (m_b[7:0] != vecs[i].target) begin
                n_run++;
                n_fail++;
                $display("FAIL search[%0d]: got %0h, expected %0h", i, m_b[7:0], vecs[i].target);
            end
            b_start = 1'b1;
            cyc(1);
            b_start = 1'b0;
            tick_b_t();
            check($sformatf("rule[%0d]", i), {8'h00, b_pattern}, {8'h00, vecs[i].expect_pat});
            check($sformatf("rule_valid[%0d]", i), {15'h0, b_valid}, 16'h0001);
            b_ui = vecs[i].expect_pat;
            cyc(1);
            b_ui = 8'h00;
            check($sformatf("rule_done[%0d]", i), {15'h0, b_done}, 16'h0001);
            check($sformatf("rule_round[%0d]", i), {8'h00, b_round}, 16'h0001);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
